// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- multi-cycle multiply/divide unit with architectural HI/LO.
//
// Sits beside the ALU in the E stage. MULT/MULTU/DIV/DIVU occupy the unit for
// a fixed number of cycles; MTHI/MTLO write HI/LO directly with no busy time.
// The arithmetic result is formed combinationally at issue and parked in
// pending registers. A down-counter then models the latency, and the pending
// result is committed to HI/LO on the counter's terminal count.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (highest priority)
//   start    issue strobe; mdu_op/in_a/in_b valid this cycle
//   mdu_op   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//   in_a     rs operand (dividend / multiplicand / MTHI-MTLO data)
//   in_b     rt operand (divisor / multiplier)
//   req      flush of the issuing instruction; suppresses this cycle's start
//   busy     operation in flight (registered, no path from start)
//   hi_out   HI register
//   lo_out   LO register
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | no operation in flight; start accepted when req is low
// ST_RUN  | mult/div in flight; counter running down, HI/LO held
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic               pend_skip;

    logic               is_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Signed multiply done as an unsigned 2W x 2W multiply on sign-extended
    // operands; the low 2W bits are the exact two's complement product.
    // Signed divide works on magnitudes so that the most-negative / -1 case
    // wraps naturally instead of overflowing a signed divider.
    always_comb begin
        is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        ext_a     = is_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
        ext_b     = is_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
        prod      = ext_a * ext_b;

        a_neg     = is_signed & in_a[WIDTH-1];
        b_neg     = is_signed & in_b[WIDTH-1];
        div_zero  = (in_b == '0);
        mag_a     = a_neg ? (~in_a + WIDTH'(1)) : in_a;
        mag_b     = b_neg ? (~in_b + WIDTH'(1)) : in_b;
        // Keep the divider away from a zero divisor; the result is discarded anyway.
        if (div_zero) begin
            mag_b = WIDTH'(1);
        end
        q_mag     = mag_a / mag_b;
        r_mag     = mag_a % mag_b;
        quo       = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
        rem       = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_skip <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !req) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi   <= prod[2*WIDTH-1:WIDTH];
                                pend_lo   <= prod[WIDTH-1:0];
                                pend_skip <= 1'b0;
                                cnt       <= MULT_LOAD;
                                busy      <= 1'b1;
                                state     <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi   <= rem;
                                pend_lo   <= quo;
                                pend_skip <= div_zero;
                                cnt       <= DIV_LOAD;
                                busy      <= 1'b1;
                                state     <= ST_RUN;
                            end
                            OP_MTHI: hi_out <= in_a;
                            OP_MTLO: lo_out <= in_a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // Terminal count: commit and drop busy on the same edge.
                    if (cnt == CNT_ONE) begin
                        if (!pend_skip) begin
                            hi_out <= pend_hi;
                            lo_out <= pend_lo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the E stage of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU over a fixed, parameter-set number of cycles and handles MTHI/MTLO writes.
- HI/LO are read directly for MFHI/MFLO; the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe: mdu_op/in_a/in_b valid this cycle.
- mdu_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op.
- in_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- in_b  input  WIDTH  rt operand (divisor / multiplier).
- req  input  1  exception/interrupt flush for the issuing instruction; suppresses that cycle's start.
- busy  output  1  operation in flight (registered).
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): busy=0, hi_out=0, lo_out=0, cycle counter=0, pending results discarded. Reset has priority over every other input, including mid-operation; no commit happens after a reset.
- Accept condition: `start & ~req & ~busy` at a rising edge. If req=1 or busy=1, the start is ignored: no state change and no queuing.
- MTHI/MTLO (accepted): hi_out or lo_out <= in_a at that edge. busy stays 0. Visible next cycle.
- MULT/DIV family (accepted at edge T):
  - Operands are captured (or the result is computed and held in temp registers).
  - Counter <= MULT_CYCLES or DIV_CYCLES.
  - busy=1 from cycle T+1.
  - Counter decrements each cycle. The edge where the counter goes 1->0 commits HI/LO and clears busy in the same edge.
  - Net effect: busy high for exactly N cycles; new HI/LO visible in the first cycle busy=0.
- hi_out/lo_out hold their old values throughout busy. Inputs changing during busy have no effect.
- MULT: signed WIDTH x WIDTH -> 2*WIDTH product; HI=upper half, LO=lower half.
- MULTU: same, unsigned.
- DIV: signed, quotient truncates toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- DIV overflow: -2^(WIDTH-1) / -1 gives LO=-2^(WIDTH-1), HI=0 (two's complement wrap).
- DIVU: unsigned; LO=quotient, HI=remainder.
- Divisor==0 (DIV or DIVU): busy still asserted for DIV_CYCLES, but HI and LO are left unchanged at commit.
- mdu_op 6/7 with start: no-op, no busy.
- req does not cancel an already in-flight operation. Only reset cancels.
- busy is a pure register output with no combinational path from start. The hazard unit combines `start` itself for same-cycle stalls.

Test Plan:
- MULT in_a=0xFFFFFFFD (-3), in_b=5, start 1 cycle -> busy=1 for exactly 5 cycles; then hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 busy cycles hi_out=0xFFFFFFFE, lo_out=0x00000001.
- DIV -7/2 -> after 10 busy cycles lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIVU 7/2 -> lo_out=3, hi_out=1. DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIVU 5/0 -> busy 10 cycles; afterwards HI/LO still 0x12345678/0x9ABCDEF0.
- Start with req=1 (MULT 2x3) -> busy stays 0 and HI/LO unchanged. Start MULTU 2x3 during an in-flight DIV -> ignored; only the DIV result commits.
- Start DIV 100/7, assert reset in busy cycle 3 -> next cycle busy=0, hi_out=lo_out=0, and they remain 0 past cycle 10.
